// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  // Bubble encoding the instantiating top drives on decode while in reset.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: asynchronous reset, load has priority over increment.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        incr,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= load_val;
    end else if (incr) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads and
// hands PC-tagged instruction words to decode over a valid/ready handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  fetch_state_t state, state_d;
  logic         kill, kill_d;
  logic         pc_load, pc_incr;
  logic         latch_instr, drop_instr;
  logic [31:0]  pc;
  logic [31:0]  redirect_target;

  assign redirect_target = align_word(redirect_pc);

  fetch_unit_pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (redirect_target),
    .incr     (pc_incr),
    .pc       (pc)
  );

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_d;
      kill  <= kill_d;
    end
  end

  // A redirect always reloads the PC; kill marks an in-flight response whose
  // address predates the redirect so it can be thrown away on arrival.
  always_comb begin
    state_d     = state;
    kill_d      = kill;
    pc_load     = redirect_valid;
    pc_incr     = 1'b0;
    latch_instr = 1'b0;
    drop_instr  = 1'b0;
    unique case (state)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          if (redirect_valid) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          if (imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill) begin
            state_d = S_REQ;
          end else begin
            latch_instr = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          drop_instr = 1'b1;
          state_d    = S_REQ;
        end else if (instr_ready) begin
          drop_instr = 1'b1;
          pc_incr    = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid  <= 1'b0;
      instr        <= 32'h0;
      instr_pc     <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (latch_instr) begin
        instr_valid <= 1'b1;
        instr       <= imem_rsp_data;
        instr_pc    <= pc;
      end else if (drop_instr) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
